// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction-fetch slice: default widths, NOP word and FSM state encoding.
package busca_instrucao_pkg;

    localparam int ADDR_WIDTH_DEF     = 6;
    localparam int INSTR_WIDTH_DEF    = 32;
    localparam int TIMEOUT_CYCLES_DEF = 15;
    localparam logic [INSTR_WIDTH_DEF-1:0] NOP_WORD_DEF = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } estado_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Memory and decoder handshake bundle of the fetch unit (master = fetch unit side).
interface busca_instrucao_if #(
    parameter int ADDR_WIDTH  = 6,
    parameter int INSTR_WIDTH = 32
);
    logic                   mem_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_ready;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_addr;
    logic                   consume;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_addr,
        input  mem_ready, mem_rdata, consume
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_addr,
        output mem_ready, mem_rdata, consume
    );
endinterface

// File: rtl/busca_instrucao_watchdog.sv
// Fetch watchdog: counts WAIT cycles without mem_ready and raises a sticky error at the limit.
module watchdog_busca #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic conta,
    output logic expira,
    output logic fetch_err
);
    logic [3:0] cnt;

    // Expire on the cycle that would bring the count to the limit.
    assign expira = conta && (cnt == 4'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (limpa || expira)
                cnt <= '0;
            else if (conta)
                cnt <= cnt + 4'd1;
            if (expira)
                fetch_err <= 1'b1;
        end
    end
endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch unit: PC -> variable-latency memory -> decoder, with redirect discard.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int INSTR_WIDTH    = INSTR_WIDTH_DEF,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD = '0,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cp,
    input  logic                  redirect,
    busca_instrucao_if.master     bus,
    output logic                  avanca_cp,
    output logic                  fetch_err
);
    estado_t                estado, estado_d;
    logic                   mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  iaddr_q, iaddr_d;
    logic                   avanca_q, avanca_d;
    logic                   descarta_q, descarta_d;
    logic                   expira;

`ifdef FETCH_TIMEOUT_EN
    watchdog_busca #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .limpa     (estado == IDLE),
        .conta     ((estado == WAIT) && !bus.mem_ready),
        .expira    (expira),
        .fetch_err (fetch_err)
    );
`else
    assign expira    = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            valid_q    <= 1'b0;
            instr_q    <= NOP_WORD;
            iaddr_q    <= '0;
            avanca_q   <= 1'b0;
            descarta_q <= 1'b0;
        end else begin
            estado     <= estado_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            iaddr_q    <= iaddr_d;
            avanca_q   <= avanca_d;
            descarta_q <= descarta_d;
        end
    end

    always_comb begin
        estado_d = estado;
        case (estado)
            IDLE:  estado_d = WAIT;
            WAIT: begin
                if (bus.mem_ready)
                    estado_d = (descarta_q || redirect) ? IDLE : VALID;
                else if (expira)
                    estado_d = IDLE;
            end
            VALID: if (redirect || bus.consume) estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        iaddr_d    = iaddr_q;
        avanca_d   = 1'b0;
        descarta_d = descarta_q;
        case (estado)
            IDLE: begin
                mem_req_d  = 1'b1;
                mem_addr_d = cp;
                descarta_d = 1'b0;
            end
            WAIT: begin
                // A redirect seen at any point of the transaction poisons its data.
                if (bus.mem_ready) begin
                    mem_req_d  = 1'b0;
                    descarta_d = 1'b0;
                    if (!(descarta_q || redirect)) begin
                        valid_d = 1'b1;
                        instr_d = bus.mem_rdata;
                        iaddr_d = mem_addr_q;
                    end
                end else if (expira) begin
                    mem_req_d  = 1'b0;
                    descarta_d = 1'b0;
                end else if (redirect) begin
                    descarta_d = 1'b1;
                end
            end
            VALID: begin
                if (redirect || bus.consume) begin
                    valid_d  = 1'b0;
                    instr_d  = NOP_WORD;
                    avanca_d = bus.consume && !redirect;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                valid_d   = 1'b0;
                instr_d   = NOP_WORD;
            end
        endcase
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = iaddr_q;
    assign avanca_cp       = avanca_q;
endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao with a transaction-level reference model.
module tb_busca_instrucao;
    localparam int AW = 6;
    localparam int IW = 32;
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] cp = '0;
    logic          redirect = 1'b0;
    logic          avanca_cp;
    logic          fetch_err;

    busca_instrucao_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    busca_instrucao #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .NOP_WORD('0), .TIMEOUT_CYCLES(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .cp        (cp),
        .redirect  (redirect),
        .bus       (bus),
        .avanca_cp (avanca_cp),
        .fetch_err (fetch_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an outstanding request, a held instruction, and flags.
    bit            m_req, m_drop, m_valid, m_adv, m_err;
    logic [AW-1:0] m_addr, m_iaddr;
    logic [IW-1:0] m_word;
    int            m_wait;

    always @(posedge clock) begin
        m_adv = 1'b0;
        if (reset) begin
            m_req = 0; m_drop = 0; m_valid = 0; m_err = 0;
            m_addr = '0; m_iaddr = '0; m_word = '0; m_wait = 0;
        end else if (!m_req && !m_valid) begin
            m_req = 1; m_addr = cp; m_drop = 0; m_wait = 0;
        end else if (m_req) begin
            if (bus.mem_ready) begin
                m_req = 0;
                if (!(m_drop || redirect)) begin
                    m_valid = 1; m_word = bus.mem_rdata; m_iaddr = m_addr;
                end
                m_drop = 0;
            end else begin
                if (redirect) m_drop = 1;
`ifdef FETCH_TIMEOUT_EN
                m_wait++;
                if (m_wait == TO) begin
                    m_err = 1; m_req = 0; m_drop = 0;
                end
`endif
            end
        end else begin
            if (redirect) m_valid = 0;
            else if (bus.consume) begin m_valid = 0; m_adv = 1; end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            chk("m.mem_req", bus.mem_req, m_req);
            if (m_req) chk("m.mem_addr", bus.mem_addr, m_addr);
            chk("m.instr_valid", bus.instr_valid, m_valid);
            chk("m.instr", bus.instr, m_valid ? m_word : '0);
            if (m_valid) chk("m.instr_addr", bus.instr_addr, m_iaddr);
            chk("m.avanca_cp", avanca_cp, m_adv);
            chk("m.fetch_err", fetch_err, m_err);
        end
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        bus.consume   = 1'b0;
        cp = 6'd5;
        // Reset state
        cyc(); cyc();
        chk("rst.mem_req", bus.mem_req, 0);
        chk("rst.mem_addr", bus.mem_addr, 0);
        chk("rst.instr_valid", bus.instr_valid, 0);
        chk("rst.instr", bus.instr, 0);
        chk("rst.instr_addr", bus.instr_addr, 0);
        chk("rst.avanca_cp", avanca_cp, 0);
        chk("rst.fetch_err", fetch_err, 0);
        reset = 1'b0;

        // First fetch, 2-cycle memory latency
        cyc();
        chk("t1.req", bus.mem_req, 1);
        chk("t1.addr", bus.mem_addr, 5);
        cyc();
        chk("t1.req_hold", bus.mem_req, 1);
        chk("t1.addr_hold", bus.mem_addr, 5);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA5A5_0001;
        cyc();
        chk("t1.valid", bus.instr_valid, 1);
        chk("t1.instr", bus.instr, 32'hA5A5_0001);
        chk("t1.iaddr", bus.instr_addr, 5);
        chk("t1.req_drop", bus.mem_req, 0);
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h1111_2222;

        // Hold 10 cycles, then consume
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t2.valid_hold", bus.instr_valid, 1);
            chk("t2.instr_hold", bus.instr, 32'hA5A5_0001);
            chk("t2.adv_hold", avanca_cp, 0);
        end
        bus.consume = 1'b1; cp = 6'd7;
        cyc();
        chk("t2.adv", avanca_cp, 1);
        chk("t2.nop", bus.instr, 0);
        chk("t2.invalid", bus.instr_valid, 0);
        bus.consume = 1'b0;
        cyc();
        chk("t2.adv_once", avanca_cp, 0);
        chk("t2.req", bus.mem_req, 1);
        chk("t2.addr", bus.mem_addr, 7);

        // Redirect during WAIT: data dropped, refetch from target
        redirect = 1'b1; cp = 6'd20;
        cyc();
        chk("t3.addr_kept", bus.mem_addr, 7);
        redirect = 1'b0;
        cyc();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("t3.dropped", bus.instr_valid, 0);
        chk("t3.idle", bus.mem_req, 0);
        bus.mem_ready = 1'b0;
        cyc();
        chk("t3.req", bus.mem_req, 1);
        chk("t3.addr", bus.mem_addr, 20);
        chk("t3.noadv", avanca_cp, 0);

        // Redirect together with consume in VALID
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
        cyc();
        chk("t4.valid", bus.instr_valid, 1);
        chk("t4.iaddr", bus.instr_addr, 20);
        bus.mem_ready = 1'b0;
        bus.consume = 1'b1; redirect = 1'b1; cp = 6'd40;
        cyc();
        chk("t4.invalid", bus.instr_valid, 0);
        chk("t4.noadv", avanca_cp, 0);
        bus.consume = 1'b0; redirect = 1'b0;
        cyc();
        chk("t4.addr", bus.mem_addr, 40);

        // Reset mid-WAIT; a late mem_ready in IDLE is ignored
        reset = 1'b1;
        cyc();
        chk("t5.req", bus.mem_req, 0);
        chk("t5.valid", bus.instr_valid, 0);
        chk("t5.addr", bus.mem_addr, 0);
        reset = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD; cp = 6'd63;
        cyc();
        chk("t5.ignored", bus.instr_valid, 0);
        chk("t5.req", bus.mem_req, 1);
        chk("t5.addr63", bus.mem_addr, 63);
        bus.mem_rdata = 32'hCAFE_003F;
        cyc();
        chk("t5.instr", bus.instr, 32'hCAFE_003F);
        chk("t5.iaddr63", bus.instr_addr, 63);
        bus.mem_ready = 1'b0; bus.consume = 1'b1; cp = 6'd0;
        cyc();
        chk("t5.adv", avanca_cp, 1);
        bus.consume = 1'b0;
        cyc();
        chk("t5.wrap_addr", bus.mem_addr, 0);

        // Memory never answers
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) begin
            cyc();
            chk("t6.req_wait", bus.mem_req, 1);
            chk("t6.err_low", fetch_err, 0);
        end
        cyc();
        chk("t6.req_drop", bus.mem_req, 0);
        chk("t6.err", fetch_err, 1);
        cyc();
        chk("t6.reissue", bus.mem_req, 1);
        chk("t6.reissue_addr", bus.mem_addr, 0);
        chk("t6.sticky", fetch_err, 1);
`else
        for (int i = 0; i < TO + 5; i++) begin
            cyc();
            chk("t6.req_wait", bus.mem_req, 1);
            chk("t6.err_tied", fetch_err, 0);
        end
`endif
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0077;
        cyc();
        chk("t6.instr", bus.instr, 32'h77);
        bus.mem_ready = 1'b0; bus.consume = 1'b1;
        cyc();
        chk("t6.adv", avanca_cp, 1);
        bus.consume = 1'b0;
        cyc(); cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
